// File: rtl/bidir_bus_port.sv
// Registered bidirectional port between the working register and the shared data bus.
// Optional conflict detection is compiled in with `define BIDIR_PORT_CONFLICT_EN.
module bidir_bus_port #(
  parameter int WIDTH       = 16,
  parameter int TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] from_wreg,
  inout  wire  [WIDTH-1:0] data,
  input  logic             mem_write,
  input  logic             mem_read,
  output logic [WIDTH-1:0] to_wreg,
  output logic             to_wreg_valid,
  output logic             data_oe,
  output logic             busy
`ifdef BIDIR_PORT_CONFLICT_EN
  ,
  output logic             conflict,
  output logic [7:0]       conflict_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, TURN} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_DRV, DIR_CAP} dir_t;

  localparam logic       TURN_EN     = (TURN_CYCLES > 0);
  localparam int         TURN_LOAD_I = (TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0;
  localparam logic [3:0] TURN_LOAD   = TURN_LOAD_I[3:0];

  state_t           state_reg, state_next;
  dir_t             dir_reg, dir_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [WIDTH-1:0] drv_reg;
  logic             load_drv, sample;
  logic             cmd_rd, cmd_wr;

  assign cmd_rd  = mem_read & ~mem_write;
  assign cmd_wr  = mem_write & ~mem_read;
  assign data_oe = (state_reg == DRIVE);
  assign busy    = (state_reg == TURN);
  assign data    = data_oe ? drv_reg : {WIDTH{1'bz}};

  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    cnt_next   = cnt_reg;
    load_drv   = 1'b0;
    sample     = 1'b0;
    case (state_reg)
      IDLE: begin
        // A command opposite to the last direction still owes the bus a turnaround.
        if (cmd_rd) begin
          dir_next = DIR_DRV;
          if (TURN_EN && dir_reg == DIR_CAP) begin
            state_next = TURN;
            cnt_next   = TURN_LOAD;
          end else begin
            state_next = DRIVE;
            load_drv   = 1'b1;
          end
        end else if (cmd_wr) begin
          dir_next = DIR_CAP;
          if (TURN_EN && dir_reg == DIR_DRV) begin
            state_next = TURN;
            cnt_next   = TURN_LOAD;
          end else begin
            state_next = CAPTURE;
            sample     = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (cmd_rd) begin
          load_drv = 1'b1;
        end else if (cmd_wr) begin
          dir_next = DIR_CAP;
          if (TURN_EN) begin
            state_next = TURN;
            cnt_next   = TURN_LOAD;
          end else begin
            state_next = CAPTURE;
            sample     = 1'b1;
          end
        end else begin
          state_next = IDLE;
        end
      end
      CAPTURE: begin
        if (cmd_wr) begin
          sample = 1'b1;
        end else if (cmd_rd) begin
          dir_next = DIR_DRV;
          if (TURN_EN) begin
            state_next = TURN;
            cnt_next   = TURN_LOAD;
          end else begin
            state_next = DRIVE;
            load_drv   = 1'b1;
          end
        end else begin
          state_next = IDLE;
        end
      end
      TURN: begin
        // Commands are only looked at again once the gap has fully elapsed.
        if (cnt_reg == 4'd0) begin
          if (cmd_rd) begin
            state_next = DRIVE;
            dir_next   = DIR_DRV;
            load_drv   = 1'b1;
          end else if (cmd_wr) begin
            state_next = CAPTURE;
            dir_next   = DIR_CAP;
            sample     = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      dir_reg       <= DIR_NONE;
      cnt_reg       <= 4'd0;
      drv_reg       <= '0;
      to_wreg       <= '0;
      to_wreg_valid <= 1'b0;
    end else begin
      state_reg     <= state_next;
      dir_reg       <= dir_next;
      cnt_reg       <= cnt_next;
      to_wreg_valid <= sample;
      if (load_drv) drv_reg <= from_wreg;
      if (sample)   to_wreg <= data;
    end
  end

`ifdef BIDIR_PORT_CONFLICT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict     <= 1'b0;
      conflict_cnt <= 8'd0;
    end else if (mem_write & mem_read) begin
      conflict <= 1'b1;
      if (conflict_cnt != 8'hFF) conflict_cnt <= conflict_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bidir_bus_port.sv
// Scoreboard bench for bidir_bus_port: one instance with a 2-cycle turnaround, one with none.
// Build with BIDIR_PORT_CONFLICT_EN defined to also exercise the conflict counter.
module tb_bidir_bus_port;

  logic clk;
  logic rst_n;

  logic        a_rd, a_wr, a_ben;
  logic [15:0] a_from, a_bval, a_to;
  logic        a_valid, a_oe, a_busy;
  wire  [15:0] a_data;

  logic        b_rd, b_wr, b_ben;
  logic [15:0] b_from, b_bval, b_to;
  logic        b_valid, b_oe, b_busy;
  wire  [15:0] b_data;

`ifdef BIDIR_PORT_CONFLICT_EN
  logic       a_conf, b_conf;
  logic [7:0] a_ccnt, b_ccnt;
`endif

  assign a_data = a_ben ? a_bval : 16'hzzzz;
  assign b_data = b_ben ? b_bval : 16'hzzzz;

  bidir_bus_port #(.WIDTH(16), .TURN_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .from_wreg(a_from), .data(a_data),
    .mem_write(a_wr), .mem_read(a_rd), .to_wreg(a_to), .to_wreg_valid(a_valid),
    .data_oe(a_oe), .busy(a_busy)
`ifdef BIDIR_PORT_CONFLICT_EN
    , .conflict(a_conf), .conflict_cnt(a_ccnt)
`endif
  );

  bidir_bus_port #(.WIDTH(16), .TURN_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .from_wreg(b_from), .data(b_data),
    .mem_write(b_wr), .mem_read(b_rd), .to_wreg(b_to), .to_wreg_valid(b_valid),
    .data_oe(b_oe), .busy(b_busy)
`ifdef BIDIR_PORT_CONFLICT_EN
    , .conflict(b_conf), .conflict_cnt(b_ccnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  logic [15:0] a_capq[$], a_drvq[$], b_capq[$], b_drvq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every presented output must match the oldest expected word.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_n) begin
      if (a_valid) begin
        if (a_capq.size() == 0) chk("a_cap_unexpected", {15'd0, a_valid}, 32'd0);
        else begin e = a_capq.pop_front(); chk("a_cap", {16'd0, a_to}, {16'd0, e});
          $display("a capture to_wreg=%h expected=%h", a_to, e); end
      end
      if (a_oe) begin
        if (a_drvq.size() == 0) chk("a_drv_unexpected", {15'd0, a_oe}, 32'd0);
        else begin e = a_drvq.pop_front(); chk("a_drv", {16'd0, a_data}, {16'd0, e});
          $display("a drive data=%h expected=%h", a_data, e); end
      end
      if (b_valid) begin
        if (b_capq.size() == 0) chk("b_cap_unexpected", {15'd0, b_valid}, 32'd0);
        else begin e = b_capq.pop_front(); chk("b_cap", {16'd0, b_to}, {16'd0, e});
          $display("b capture to_wreg=%h expected=%h", b_to, e); end
      end
      if (b_oe) begin
        if (b_drvq.size() == 0) chk("b_drv_unexpected", {15'd0, b_oe}, 32'd0);
        else begin e = b_drvq.pop_front(); chk("b_drv", {16'd0, b_data}, {16'd0, e});
          $display("b drive data=%h expected=%h", b_data, e); end
      end
    end
  end

  task automatic cyc_a(input logic rd, input logic wr, input logic [15:0] from,
                       input logic ben, input logic [15:0] bval);
    a_rd = rd; a_wr = wr; a_from = from; a_ben = ben; a_bval = bval;
    @(negedge clk);
  endtask

  task automatic cyc_b(input logic rd, input logic wr, input logic [15:0] from,
                       input logic ben, input logic [15:0] bval);
    b_rd = rd; b_wr = wr; b_from = from; b_ben = ben; b_bval = bval;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    a_rd = 0; a_wr = 0; a_from = 0; a_ben = 0; a_bval = 0;
    b_rd = 0; b_wr = 0; b_from = 0; b_ben = 0; b_bval = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_to_wreg", {16'd0, a_to}, 32'd0);
    chk("rst_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_oe", {31'd0, a_oe}, 32'd0);
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    rst_n = 1'b1;

    // Drive path with one-cycle lag on from_wreg
    a_drvq.push_back(16'hA5A5);
    cyc_a(1, 0, 16'hA5A5, 0, 0);
    chk("drive_oe", {31'd0, a_oe}, 32'd1);
    a_drvq.push_back(16'h1234);
    cyc_a(1, 0, 16'h1234, 0, 0);

    // DRIVE -> CAPTURE through two turnaround cycles
    cyc_a(0, 1, 16'h1234, 0, 0);
    chk("turn1_busy", {31'd0, a_busy}, 32'd1);
    chk("turn1_oe", {31'd0, a_oe}, 32'd0);
    a_capq.push_back(16'hBEEF);
    cyc_a(0, 1, 16'h1234, 1, 16'hBEEF);
    chk("turn2_busy", {31'd0, a_busy}, 32'd1);
    chk("turn2_oe", {31'd0, a_oe}, 32'd0);
    cyc_a(0, 1, 16'h1234, 1, 16'hBEEF);
    chk("cap_busy", {31'd0, a_busy}, 32'd0);

    // Held capture, one sample per edge
    for (int i = 1; i <= 4; i++) begin
      a_capq.push_back(16'(i));
      cyc_a(0, 1, 16'h1234, 1, 16'(i));
      chk("held_valid", {31'd0, a_valid}, 32'd1);
    end
    chk("held_last", {16'd0, a_to}, 32'h0004);
    cyc_a(0, 0, 16'h1234, 0, 0);
    chk("drop_valid", {31'd0, a_valid}, 32'd0);
    chk("drop_hold", {16'd0, a_to}, 32'h0004);

    // IDLE after capture, read request still owes a turnaround
    cyc_a(1, 0, 16'h5555, 0, 0);
    chk("idle_turn1_busy", {31'd0, a_busy}, 32'd1);
    cyc_a(1, 0, 16'h5555, 0, 0);
    chk("idle_turn2_busy", {31'd0, a_busy}, 32'd1);
    a_drvq.push_back(16'h5555);
    cyc_a(1, 0, 16'h5555, 0, 0);
    chk("idle_turn_exit_oe", {31'd0, a_oe}, 32'd1);
    chk("idle_turn_exit_busy", {31'd0, a_busy}, 32'd0);

    // Both requests: bus released, nothing captured
`ifdef BIDIR_PORT_CONFLICT_EN
    chk("conflict_clear", {31'd0, a_conf}, 32'd0);
`endif
    cyc_a(1, 1, 16'h5555, 0, 0);
    chk("both_oe", {31'd0, a_oe}, 32'd0);
    chk("both_valid", {31'd0, a_valid}, 32'd0);
`ifdef BIDIR_PORT_CONFLICT_EN
    chk("conflict_one", {24'd0, a_ccnt}, 32'd1);
    for (int i = 0; i < 299; i++) cyc_a(1, 1, 16'h5555, 0, 0);
    chk("conflict_sticky", {31'd0, a_conf}, 32'd1);
    chk("conflict_sat", {24'd0, a_ccnt}, 32'd255);
`endif

    // Asynchronous reset while driving
    a_drvq.push_back(16'h0F0F);
    cyc_a(1, 0, 16'h0F0F, 0, 0);
    chk("pre_rst_oe", {31'd0, a_oe}, 32'd1);
    a_rd = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_oe", {31'd0, a_oe}, 32'd0);
    chk("async_rst_to_wreg", {16'd0, a_to}, 32'd0);
    chk("async_rst_busy", {31'd0, a_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-turnaround instance: direction changes in one edge
    b_drvq.push_back(16'h00AA);
    cyc_b(1, 0, 16'h00AA, 0, 0);
    chk("b_drive_oe", {31'd0, b_oe}, 32'd1);
    b_capq.push_back(16'h00AA);
    cyc_b(0, 1, 16'h00AA, 0, 0);
    chk("b_switch_oe", {31'd0, b_oe}, 32'd0);
    chk("b_switch_busy", {31'd0, b_busy}, 32'd0);
    chk("b_switch_valid", {31'd0, b_valid}, 32'd1);
    b_capq.push_back(16'h0BB0);
    cyc_b(0, 1, 16'h00AA, 1, 16'h0BB0);
    chk("b_cap_busy", {31'd0, b_busy}, 32'd0);
    b_drvq.push_back(16'h1111);
    cyc_b(1, 0, 16'h1111, 0, 0);
    chk("b_back_oe", {31'd0, b_oe}, 32'd1);
    chk("b_back_busy", {31'd0, b_busy}, 32'd0);
    cyc_b(0, 0, 16'h1111, 0, 0);
    chk("b_idle_oe", {31'd0, b_oe}, 32'd0);

    @(negedge clk);
    chk("a_capq_empty", a_capq.size(), 32'd0);
    chk("a_drvq_empty", a_drvq.size(), 32'd0);
    chk("b_capq_empty", b_capq.size(), 32'd0);
    chk("b_drvq_empty", b_drvq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
